// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus arbiter: FSM state codes and master IDs.
package mio_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_ACCESS = 2'd1;
   localparam state_t ST_DONE   = 2'd2;

   localparam logic M_CPU = 1'b0;
   localparam logic M_DMA = 1'b1;

endpackage

// File: rtl/mio_bus_arbiter_rr_arb2.sv
// Combinational two-way pick between CPU and DMA requests.
module rr_arb2
   import mio_pkg::*;
#(
   parameter int ROUND_ROBIN = 1
) (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic gnt_id,
   output logic any
);

   always_comb begin
      any = req0 | req1;
      if (req0 && req1) begin
         // On a tie, round-robin hands the port to whoever did not win last.
         gnt_id = (ROUND_ROBIN != 0) ? ~last : M_CPU;
      end else if (req1) begin
         gnt_id = M_DMA;
      end else begin
         gnt_id = M_CPU;
      end
   end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Shares one fixed-latency memory port between the CPU (M0) and the DMA (M1),
// one transaction at a time, with a registered one-cycle ready per master.
module mio_bus_arbiter
   import mio_pkg::*;
#(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int MEM_LAT     = 2,
   parameter int ROUND_ROBIN = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_ready,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_ready,
   output logic [DW-1:0] m1_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          grant_id
);

   localparam int CW = $clog2(MEM_LAT + 1);

   state_t          state_reg;
   logic [CW-1:0]   cnt_reg;
   logic            last_reg;
   logic            grant_reg;
   logic            we_reg;
   logic [AW-1:0]   addr_reg;
   logic [DW-1:0]   wdata_reg;
   logic            pick_id;
   logic            pick_any;
   logic            access_last;

   rr_arb2 #(
      .ROUND_ROBIN(ROUND_ROBIN)
   ) u_arb (
      .req0  (m0_req),
      .req1  (m1_req),
      .last  (last_reg),
      .gnt_id(pick_id),
      .any   (pick_any)
   );

   assign access_last = (state_reg == ST_ACCESS) && (cnt_reg == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         last_reg  <= M_DMA;
         grant_reg <= M_CPU;
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (pick_any) begin
                  state_reg <= ST_ACCESS;
                  cnt_reg   <= CW'(MEM_LAT - 1);
                  last_reg  <= pick_id;
                  grant_reg <= pick_id;
                  we_reg    <= pick_id ? m1_we    : m0_we;
                  addr_reg  <= pick_id ? m1_addr  : m0_addr;
                  wdata_reg <= pick_id ? m1_wdata : m0_wdata;
               end
            end
            ST_ACCESS: begin
               if (cnt_reg == '0) begin
                  state_reg <= ST_DONE;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            ST_DONE: state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Per-master completion pulse and read-data holding register.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_master
         logic          ready_reg;
         logic [DW-1:0] rdata_reg;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               ready_reg <= 1'b0;
               rdata_reg <= '0;
            end else begin
               ready_reg <= access_last && (grant_reg == 1'(gi));
               if (access_last && (grant_reg == 1'(gi)) && !we_reg) begin
                  rdata_reg <= mem_rdata;
               end
            end
         end
      end
   endgenerate

   assign m0_ready = g_master[0].ready_reg;
   assign m0_rdata = g_master[0].rdata_reg;
   assign m1_ready = g_master[1].ready_reg;
   assign m1_rdata = g_master[1].rdata_reg;

   assign mem_en    = (state_reg == ST_ACCESS);
   assign mem_we    = mem_en & we_reg;
   assign mem_addr  = mem_en ? addr_reg  : '0;
   assign mem_wdata = mem_en ? wdata_reg : '0;
   assign busy      = (state_reg == ST_ACCESS) || (state_reg == ST_DONE);
   assign grant_id  = grant_reg;

endmodule
